incdec_monitor: RTL and testbench
=================================

// Module: incdec_monitor
// PURPOSE
//  Downstream checker for the inc/dec counter pair. Samples both counts each valid cycle.
//  Verifies that inc steps +1 and dec steps -1 (mod 2^WIDTH).
//  Reports meet points, wrap-arounds and continuity errors as event records.
//  Events leave through a valid/ready queue to a logger or debug bus.
// PARAMETERS
//  WIDTH    4   counter width; must match the upstream counter
//  DEPTH    4   event queue entries; power of two, >= 2
//  CNT_W    8   width of the meet and drop counters
// PORTS
//  i_clk           in   1      clock, rising edge
//  i_reset         in   1      synchronous reset, active high
//  i_valid         in   1      i_inc/i_dec hold a valid counter sample this cycle
//  i_inc           in   WIDTH  incrementing count
//  i_dec           in   WIDTH  decrementing count
//  o_evt_valid     out  1      event record available at queue head
//  i_evt_ready     in   1      consumer accepts the head record
//  o_evt_code      out  2      00 MEET, 01 INC_WRAP, 10 DEC_WRAP, 11 CONT_ERR
//  o_evt_value     out  WIDTH  i_inc value of the sample that raised the event
//  o_err           out  1      sticky continuity-error flag
//  o_meet_cnt      out  CNT_W  MEET events detected; saturates at all-ones
//  o_drop_cnt      out  CNT_W  events lost to a full queue; saturates at all-ones
// BEHAVIOUR
//  Reset (i_reset=1 at posedge):
//   - State goes to S_IDLE; queue is flushed.
//   - All outputs read 0 on the next cycle. Reset overrides every other input in that cycle.
//  FSM states: S_IDLE (no reference sample), S_TRACK, S_ERROR.
//   S_IDLE,  i_valid=1:  capture prv_inc/prv_dec; evaluate MEET only; go to S_TRACK.
//   S_TRACK, i_valid=1:  evaluate all checks against prv_*; update prv_*.
//   S_TRACK, i_valid=0:  go to S_IDLE (resync); no event.
//   S_TRACK, CONT_ERR:   go to S_ERROR.
//   S_ERROR:             ignore inputs; leave only on reset.
//  Checks (all arithmetic mod 2^WIDTH):
//   - CONT_ERR: i_inc != prv_inc+1, or i_dec != prv_dec-1.
//   - MEET:     i_inc == i_dec.
//   - INC_WRAP: prv_inc == all-ones and i_inc == 0.
//   - DEC_WRAP: prv_dec == 0 and i_dec == all-ones.
//  Event generation:
//   - At most one event per sample. Priority: CONT_ERR > MEET > INC_WRAP > DEC_WRAP.
//   - Each lower-priority event suppressed in the same sample increments o_drop_cnt.
//   - o_meet_cnt increments on every detected MEET, even if the event is dropped.
//   - o_err sets in the same cycle the CONT_ERR event is pushed.
//  Queue:
//   - Push and pop each take effect at the posedge.
//   - Push latency: the record is visible at the head on the cycle after its sample.
//   - Pop occurs when o_evt_valid && i_evt_ready.
//   - Full without pop: the new event is dropped and o_drop_cnt increments.
//   - Full with pop in the same cycle: the push is accepted; no drop.
//   - Empty with push: o_evt_valid rises next cycle. There is no same-cycle bypass.
//   - While o_evt_valid=1 and i_evt_ready=0, o_evt_code/o_evt_value stay stable.
//  Counters saturate; they never wrap.
// STRUCTURE
//  Shared package incdec_pkg:
//   - EVT_MEET/EVT_INC_WRAP/EVT_DEC_WRAP/EVT_CONT_ERR codes
//   - S_IDLE/S_TRACK/S_ERROR encodings
//   - event record width (2+WIDTH)
//  Sub-module evt_fifo (DEPTH x (2+WIDTH) circular queue):
//   - ports: push/pop/full/empty, head data
//  Top level holds the FSM, checkers, priority encoder and counters.
// TESTING
//  1. Upstream counter reset releases to inc=dec=4, then free-runs ->
//     MEET(value 4) on the first sample, DEC_WRAP(value 9), MEET(value 12), INC_WRAP(value 0).
//  2. i_evt_ready held 0 and five events generated (DEPTH=4) ->
//     4 queued, o_drop_cnt=1, head stable; then drain in order.
//  3. Queue full; pop and push in the same cycle -> no drop; count stays 4.
//  4. Sample inc 6->8 in S_TRACK -> CONT_ERR(value 8), o_err=1;
//     later MEETs produce no events; o_meet_cnt frozen.
//  5. i_valid low for one cycle, then a non-consecutive sample ->
//     no CONT_ERR (resync through S_IDLE).
//  6. i_reset asserted with 3 queued events and o_err=1 ->
//     next cycle o_evt_valid=0, o_err=0, counters 0, state S_IDLE.

Source files
------------

// File: rtl/incdec_pkg.sv
// incdec_pkg: shared event codes, FSM encodings and record width for the inc/dec monitor
package incdec_pkg;
    typedef enum logic [1:0] {
        EVT_MEET     = 2'b00,
        EVT_INC_WRAP = 2'b01,
        EVT_DEC_WRAP = 2'b10,
        EVT_CONT_ERR = 2'b11
    } evt_t;
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ERROR} state_t;
    localparam int EVT_CODE_W = 2;
    function automatic int rec_w(input int width);
        return EVT_CODE_W + width;
    endfunction
endpackage

// File: rtl/incdec_monitor_if.sv
// incdec_monitor_if: counter sample inputs, event queue handshake and status outputs
interface incdec_monitor_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
    logic             i_valid;
    logic [WIDTH-1:0] i_inc;
    logic [WIDTH-1:0] i_dec;
    logic             o_evt_valid;
    logic             i_evt_ready;
    logic [1:0]       o_evt_code;
    logic [WIDTH-1:0] o_evt_value;
    logic             o_err;
    logic [CNT_W-1:0] o_meet_cnt;
    logic [CNT_W-1:0] o_drop_cnt;
    modport master (
        output i_valid, i_inc, i_dec, i_evt_ready,
        input  o_evt_valid, o_evt_code, o_evt_value, o_err, o_meet_cnt, o_drop_cnt
    );
    modport slave (
        input  i_valid, i_inc, i_dec, i_evt_ready,
        output o_evt_valid, o_evt_code, o_evt_value, o_err, o_meet_cnt, o_drop_cnt
    );
endinterface

// File: rtl/incdec_monitor_evt_fifo.sv
// evt_fifo: circular event queue; a pop frees a slot for a push in the same cycle
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push, w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rp];
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/incdec_monitor.sv
// incdec_monitor: checks inc/dec counter continuity and queues meet/wrap/error events
module incdec_monitor
    import incdec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic             i_clk,
    input logic             i_reset,
    incdec_monitor_if.slave bus
);
    localparam int RW = rec_w(WIDTH);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_prv_inc, r_prv_dec;
    logic             r_err;
    logic [CNT_W-1:0] r_meet_cnt, r_drop_cnt;
    logic             w_sample, w_track, w_cont, w_meet, w_incw, w_decw;
    logic             w_push, w_pop, w_full, w_empty;
    evt_t             w_code;
    logic [2:0]       w_drop_inc;
    logic [CNT_W:0]   w_drop_sum;
    logic [RW-1:0]    w_head;
    always_comb begin
        w_sample   = bus.i_valid && r_state != S_ERROR;
        w_track    = bus.i_valid && r_state == S_TRACK;
        w_cont     = w_track && (bus.i_inc != WIDTH'(r_prv_inc + 1'b1) ||
                                 bus.i_dec != WIDTH'(r_prv_dec - 1'b1));
        w_meet     = w_sample && bus.i_inc == bus.i_dec;
        w_incw     = w_track && &r_prv_inc && bus.i_inc == '0;
        w_decw     = w_track && r_prv_dec == '0 && &bus.i_dec;
        w_push     = w_cont || w_meet || w_incw || w_decw;
        w_code     = w_cont ? EVT_CONT_ERR : w_meet ? EVT_MEET : w_incw ? EVT_INC_WRAP : EVT_DEC_WRAP;
        w_pop      = bus.i_evt_ready && !w_empty;
        // suppressed lower-priority events plus a winner lost to a full queue
        w_drop_inc = 3'(w_cont) + 3'(w_meet) + 3'(w_incw) + 3'(w_decw) - 3'(w_push)
                   + 3'(w_push && w_full && !w_pop);
        w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_inc);
        w_next     = (r_state == S_ERROR || w_cont) ? S_ERROR : bus.i_valid ? S_TRACK : S_IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prv_inc  <= '0;
            r_prv_dec  <= '0;
            r_err      <= 1'b0;
            r_meet_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_sample) begin
                r_prv_inc <= bus.i_inc;
                r_prv_dec <= bus.i_dec;
            end
            if (w_cont) r_err <= 1'b1;
            if (w_meet && !(&r_meet_cnt)) r_meet_cnt <= r_meet_cnt + 1'b1;
            r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
        end
    end
    evt_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({w_code, bus.i_inc}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );
    assign bus.o_evt_valid = !w_empty;
    assign bus.o_evt_code  = w_head[RW-1 -: 2];
    assign bus.o_evt_value = w_head[WIDTH-1:0];
    assign bus.o_err       = r_err;
    assign bus.o_meet_cnt  = r_meet_cnt;
    assign bus.o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_incdec_monitor.sv
// tb_incdec_monitor: vector table plus scoreboard of expected event records
module tb_incdec_monitor;
    import incdec_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   pops  = 0;
    logic [5:0] sb[$];
    typedef struct {
        logic       v;
        logic [3:0] inc;
        logic [3:0] dec;
        logic       has_evt;
        logic [1:0] code;
    } vec_t;
    vec_t tbl[13];
    incdec_monitor_if #(.WIDTH(4), .CNT_W(8)) bus ();
    incdec_monitor #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && bus.o_evt_valid && bus.i_evt_ready) begin
            pops++;
            if (sb.size() == 0) check("unexpected_evt", {bus.o_evt_code, bus.o_evt_value}, -1);
            else check("evt_record", {bus.o_evt_code, bus.o_evt_value}, sb.pop_front());
        end
    end
    task automatic drive(input logic v, input logic [3:0] inc, input logic [3:0] dec);
        bus.i_valid = v;
        bus.i_inc   = inc;
        bus.i_dec   = dec;
        @(posedge clk);
        #1;
    endtask
    task automatic expect_evt(input logic [1:0] code, input logic [3:0] val);
        sb.push_back({code, val});
    endtask
    task automatic drain(input string name);
        bus.i_evt_ready = 1'b1;
        for (int i = 0; i < 20 && bus.o_evt_valid; i++) drive(1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 4'd0);
        check({name, "_empty"}, int'(bus.o_evt_valid), 0);
        check({name, "_sb_left"}, sb.size(), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int p0;
        bus.i_valid = 1'b0;
        bus.i_inc = '0;
        bus.i_dec = '0;
        bus.i_evt_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tbl[i].v = 1'b1;
            tbl[i].inc = 4'(4 + i);
            tbl[i].dec = 4'(4 - i);
            tbl[i].has_evt = 1'b0;
            tbl[i].code = EVT_MEET;
        end
        tbl[0].has_evt = 1'b1;
        tbl[5].has_evt = 1'b1;
        tbl[5].code = EVT_DEC_WRAP;
        tbl[8].has_evt = 1'b1;
        tbl[12].has_evt = 1'b1;
        tbl[12].code = EVT_INC_WRAP;
        drive(1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        check("rst_evt_valid", int'(bus.o_evt_valid), 0);
        check("rst_err", int'(bus.o_err), 0);
        check("rst_meet_cnt", int'(bus.o_meet_cnt), 0);
        check("rst_drop_cnt", int'(bus.o_drop_cnt), 0);
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].has_evt) expect_evt(tbl[i].code, tbl[i].inc);
            drive(tbl[i].v, tbl[i].inc, tbl[i].dec);
            check("freerun_err", int'(bus.o_err), 0);
        end
        drive(1'b0, 4'd0, 4'd0);
        check("freerun_meet_cnt", int'(bus.o_meet_cnt), 2);
        check("freerun_drop_cnt", int'(bus.o_drop_cnt), 0);
        drive(1'b1, 4'd3, 4'd7);
        drive(1'b1, 4'd4, 4'd6);
        drive(1'b0, 4'd0, 4'd0);
        check("resync_err", int'(bus.o_err), 0);
        check("resync_sb", sb.size(), 0);
        bus.i_evt_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) expect_evt(EVT_MEET, 4'(k));
            drive(1'b1, 4'(k), 4'(k));
            drive(1'b0, 4'd0, 4'd0);
            check("hold_head", {bus.o_evt_code, bus.o_evt_value}, {EVT_MEET, 4'd1});
        end
        check("full_drop_cnt", int'(bus.o_drop_cnt), 1);
        check("full_meet_cnt", int'(bus.o_meet_cnt), 7);
        expect_evt(EVT_MEET, 4'd6);
        bus.i_evt_ready = 1'b1;
        drive(1'b1, 4'd6, 4'd6);
        bus.i_evt_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0);
        check("poppush_drop_cnt", int'(bus.o_drop_cnt), 1);
        check("poppush_head", {bus.o_evt_code, bus.o_evt_value}, {EVT_MEET, 4'd2});
        p0 = pops;
        drain("drain1");
        check("drain1_count", pops - p0, 4);
        drive(1'b1, 4'd5, 4'd9);
        drive(1'b1, 4'd6, 4'd8);
        expect_evt(EVT_CONT_ERR, 4'd8);
        drive(1'b1, 4'd8, 4'd7);
        check("cont_err_flag", int'(bus.o_err), 1);
        drive(1'b1, 4'd7, 4'd7);
        drive(1'b1, 4'd9, 4'd9);
        drain("err");
        check("err_meet_frozen", int'(bus.o_meet_cnt), 8);
        check("err_sticky", int'(bus.o_err), 1);
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        bus.i_evt_ready = 1'b0;
        drive(1'b1, 4'd3, 4'd3);
        drive(1'b0, 4'd0, 4'd0);
        drive(1'b1, 4'd5, 4'd5);
        drive(1'b1, 4'd7, 4'd4);
        check("pre_rst_valid", int'(bus.o_evt_valid), 1);
        check("pre_rst_err", int'(bus.o_err), 1);
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        check("rst2_evt_valid", int'(bus.o_evt_valid), 0);
        check("rst2_err", int'(bus.o_err), 0);
        check("rst2_meet_cnt", int'(bus.o_meet_cnt), 0);
        check("rst2_drop_cnt", int'(bus.o_drop_cnt), 0);
        bus.i_evt_ready = 1'b1;
        expect_evt(EVT_MEET, 4'd8);
        drive(1'b1, 4'd8, 4'd8);
        drive(1'b1, 4'd9, 4'd7);
        drain("post_rst");
        check("post_rst_err", int'(bus.o_err), 0);
        check("post_rst_meet_cnt", int'(bus.o_meet_cnt), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
